// File: rtl/button_debounce.sv
// ---------------------------------------------------------------------------
// button_debounce
//
// Multi-channel push-button debouncer. Each channel brings an asynchronous
// contact into the clk domain through a SYNC_STAGES flop chain, then runs a
// four-state filter. A new level is accepted only after the synchronised
// input has held it for DEBOUNCE_CYCLES consecutive edges. Aborted
// confirmations are counted as glitches in a saturating 8-bit counter per
// channel.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   raw[N]       asynchronous raw contacts, 1 = pressed
//   level[N]     debounced registered level, feeds the interrupt source `in`
//   rise[N]      one-cycle pulse coincident with level 0->1
//   fall[N]      one-cycle pulse coincident with level 1->0
//   glitch_sel   channel index for the glitch readout
//   glitch_count glitch counter of the selected channel (combinational mux)
//   glitch_clr   synchronous clear of every glitch counter
// ---------------------------------------------------------------------------
module button_debounce #(
  parameter int N               = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16,
  localparam int SEL_W          = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     raw,
  output logic [N-1:0]     level,
  output logic [N-1:0]     rise,
  output logic [N-1:0]     fall,
  input  logic [SEL_W-1:0] glitch_sel,
  output logic [7:0]       glitch_count,
  input  logic             glitch_clr
);

  typedef enum logic [1:0] {
    STABLE_LOW   = 2'd0,
    CONFIRM_HIGH = 2'd1,
    STABLE_HIGH  = 2'd2,
    CONFIRM_LOW  = 2'd3
  } state_t;

  // Terminal count of a confirmation window: the edge that sees the new
  // value for the DEBOUNCE_CYCLES-th time accepts it.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Saturating increment for the glitch counters: holds at 255, never wraps.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'hFF) begin
      return v;
    end
    return v + 8'd1;
  endfunction

  logic [7:0] glitch_arr [N];

  for (genvar i = 0; i < N; i++) begin : g_ch

    logic [SYNC_STAGES-1:0] sync_p;
    logic                   s;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic [7:0]             glitch_q, glitch_d;
    logic                   glitch_hit;

    // --- synchroniser: raw enters at bit 0, FSM reads the last stage only ---
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        sync_p <= '0;
      end else begin
        sync_p <= {sync_p[SYNC_STAGES-2:0], raw[i]};
      end
    end

    assign s = sync_p[SYNC_STAGES-1];

    // --- filter FSM: next state, counter, outputs ---
    always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      level_d    = level_q;
      rise_d     = 1'b0;
      fall_d     = 1'b0;
      glitch_hit = 1'b0;

      unique case (state_q)
        STABLE_LOW: begin
          level_d = 1'b0;
          if (s) begin
            state_d = CONFIRM_HIGH;
            cnt_d   = CNT_W'(1);
          end
        end

        CONFIRM_HIGH: begin
          level_d = 1'b0;
          if (!s) begin
            state_d    = STABLE_LOW;
            cnt_d      = '0;
            glitch_hit = 1'b1;
          end else if (cnt_q == CNT_LAST) begin
            state_d = STABLE_HIGH;
            cnt_d   = '0;
            level_d = 1'b1;
            rise_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        STABLE_HIGH: begin
          level_d = 1'b1;
          if (!s) begin
            state_d = CONFIRM_LOW;
            cnt_d   = CNT_W'(1);
          end
        end

        CONFIRM_LOW: begin
          level_d = 1'b1;
          if (s) begin
            state_d    = STABLE_HIGH;
            cnt_d      = '0;
            glitch_hit = 1'b1;
          end else if (cnt_q == CNT_LAST) begin
            state_d = STABLE_LOW;
            cnt_d   = '0;
            level_d = 1'b0;
            fall_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        default: begin
          state_d = STABLE_LOW;
          cnt_d   = '0;
          level_d = 1'b0;
        end
      endcase

      // A clear in the same cycle as a glitch wins.
      if (glitch_clr) begin
        glitch_d = 8'd0;
      end else if (glitch_hit) begin
        glitch_d = sat_inc8(glitch_q);
      end else begin
        glitch_d = glitch_q;
      end
    end

    // --- registered state and outputs ---
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state_q  <= STABLE_LOW;
        cnt_q    <= '0;
        level_q  <= 1'b0;
        rise_q   <= 1'b0;
        fall_q   <= 1'b0;
        glitch_q <= 8'd0;
      end else begin
        state_q  <= state_d;
        cnt_q    <= cnt_d;
        level_q  <= level_d;
        rise_q   <= rise_d;
        fall_q   <= fall_d;
        glitch_q <= glitch_d;
      end
    end

    assign level[i]      = level_q;
    assign rise[i]       = rise_q;
    assign fall[i]       = fall_q;
    assign glitch_arr[i] = glitch_q;

  end : g_ch

  // Out-of-range selects (N not a power of two) read as zero.
  always_comb begin
    glitch_count = 8'd0;
    if (32'(glitch_sel) < N) begin
      glitch_count = glitch_arr[glitch_sel];
    end
  end

endmodule

// File: tb/tb_button_debounce.sv
// ---------------------------------------------------------------------------
// tb_button_debounce
//
// Directed bench for button_debounce with N=4, SYNC_STAGES=2,
// DEBOUNCE_CYCLES=4. Inputs change 1 time unit after a rising edge; outputs
// are sampled at the same point, so "after edge Ek" means the value
// registered by edge k. E0 is the first edge that samples a new raw value;
// acceptance lands on E0+2+4-1 = E5.
// ---------------------------------------------------------------------------
module tb_button_debounce;

  localparam int N     = 4;
  localparam int SYNC  = 2;
  localparam int DEB   = 4;
  localparam int CNT_W = 16;
  localparam int SEL_W = 2;

  logic             clk;
  logic             rst_n;
  logic [N-1:0]     raw;
  logic [N-1:0]     level;
  logic [N-1:0]     rise;
  logic [N-1:0]     fall;
  logic [SEL_W-1:0] glitch_sel;
  logic [7:0]       glitch_count;
  logic             glitch_clr;

  int n_checks;
  int n_errors;

  button_debounce #(
    .N              (N),
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .raw         (raw),
    .level       (level),
    .rise        (rise),
    .fall        (fall),
    .glitch_sel  (glitch_sel),
    .glitch_count(glitch_count),
    .glitch_clr  (glitch_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rise_acc;
    int fall_acc;

    n_checks   = 0;
    n_errors   = 0;
    rst_n      = 1'b0;
    raw        = '0;
    glitch_sel = '0;
    glitch_clr = 1'b0;

    // Reset state
    ticks(2);
    check("rst_level", level, 4'h0);
    check("rst_rise", rise, 4'h0);
    check("rst_fall", fall, 4'h0);
    check("rst_glitch0", glitch_count, 8'd0);
    rst_n = 1'b1;

    // 1. Clean press on channel 0
    raw[0] = 1'b1;
    tick();                                   // E0
    ticks(3);                                 // E1..E3
    tick();                                   // E4
    check("t1_level_e4", level, 4'h0);
    check("t1_rise_e4", rise, 4'h0);
    tick();                                   // E5
    check("t1_level_e5", level, 4'h1);
    check("t1_rise_e5", rise, 4'h1);
    tick();                                   // E6
    check("t1_rise_e6", rise, 4'h0);
    check("t1_level_e6", level, 4'h1);

    // 2. Bounce on channel 1: 1,0,1,0 then hold 1 from E4 -> rise at E9
    rise_acc = 0;
    raw[1] = 1'b1; tick(); rise_acc += int'(rise[1]);   // E0
    raw[1] = 1'b0; tick(); rise_acc += int'(rise[1]);   // E1
    raw[1] = 1'b1; tick(); rise_acc += int'(rise[1]);   // E2
    raw[1] = 1'b0; tick(); rise_acc += int'(rise[1]);   // E3
    raw[1] = 1'b1;
    for (int k = 4; k <= 14; k++) begin
      tick();
      rise_acc += int'(rise[1]);
      if (k == 8) check("t2_level_e8", 32'(level[1]), 32'd0);
      if (k == 9) check("t2_rise_e9", 32'(rise[1]), 32'd1);
    end
    check("t2_rise_once", rise_acc, 32'd1);
    check("t2_level_hold", level, 4'h3);
    glitch_sel = 2'd1;
    #1;
    check("t2_glitch1", glitch_count, 8'd2);

    // 3. Release on channel 2, with an earlier one-cycle low glitch
    raw[2] = 1'b1;
    ticks(8);
    check("t3_level_high", 32'(level[2]), 32'd1);
    fall_acc = 0;
    raw[2] = 1'b0; tick(); fall_acc += int'(fall[2]);
    raw[2] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      fall_acc += int'(fall[2]);
    end
    check("t3_glitch_nofall", fall_acc, 32'd0);
    check("t3_glitch_level", 32'(level[2]), 32'd1);
    glitch_sel = 2'd2;
    #1;
    check("t3_glitch2", glitch_count, 8'd1);
    raw[2] = 1'b0;
    tick();                                   // E0
    ticks(3);
    tick();                                   // E4
    check("t3_fall_e4", 32'(fall[2]), 32'd0);
    check("t3_level_e4", 32'(level[2]), 32'd1);
    tick();                                   // E5
    check("t3_fall_e5", fall, 4'h4);
    check("t3_level_e5", level, 4'h3);
    tick();                                   // E6
    check("t3_fall_e6", fall, 4'h0);

    // 4. Saturation and clear on channel 3
    glitch_sel = 2'd3;
    for (int k = 0; k < 300; k++) begin
      raw[3] = 1'b1; tick();
      raw[3] = 1'b0; tick();
    end
    ticks(3);
    check("t4_sat", glitch_count, 8'd255);
    check("t4_level3", 32'(level[3]), 32'd0);
    raw[3] = 1'b1; tick();                    // E0
    raw[3] = 1'b0; tick();                    // E1
    tick();                                   // E2: enters CONFIRM_HIGH
    glitch_clr = 1'b1;
    tick();                                   // E3: glitch and clear together
    glitch_clr = 1'b0;
    check("t4_clr_coincident", glitch_count, 8'd0);
    tick();
    check("t4_clr_hold", glitch_count, 8'd0);

    // 5. Reset mid-confirmation
    raw   = '0;
    rst_n = 1'b0;
    ticks(2);
    rst_n = 1'b1;
    ticks(2);
    raw[0] = 1'b1;
    ticks(3);                                 // FSM is now confirming high
    rst_n = 1'b0;
    tick();
    check("t5_rst_level", level, 4'h0);
    check("t5_rst_rise", rise, 4'h0);
    check("t5_rst_fall", fall, 4'h0);
    rst_n = 1'b1;
    rise_acc = 0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      rise_acc += int'(rise[0]);
      if (k == 5) check("t5_level_pre", 32'(level[0]), 32'd0);
      if (k == 6) check("t5_rise", rise, 4'h1);
    end
    check("t5_rise_once", rise_acc, 32'd1);

    // 6. Parallel acceptance on all channels
    raw   = '0;
    rst_n = 1'b0;
    ticks(2);
    rst_n = 1'b1;
    raw   = 4'hF;
    tick();                                   // E0
    ticks(3);
    tick();                                   // E4
    check("t6_rise_e4", rise, 4'h0);
    tick();                                   // E5
    check("t6_rise_e5", rise, 4'hF);
    check("t6_level_e5", level, 4'hF);
    check("t6_fall_e5", fall, 4'h0);
    tick();                                   // E6
    check("t6_rise_e6", rise, 4'h0);
    check("t6_level_e6", level, 4'hF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
